// File: rtl/prs_word_gen.sv
// Pseudo-random 16-bit word generator feeding the SPI slave TX buffer.
// A Galois LFSR steps once per clock to build a word after each captured frame command.
module prs_word_gen #(
  parameter int unsigned             WORD_BITS = 16,
  parameter logic [WORD_BITS-1:0]    TAPS      = 16'hB400,
  parameter logic [WORD_BITS-1:0]    SEED      = 16'hACE1,
  parameter int unsigned             CNT_BITS  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_capt_st,
  input  logic [1:0]           i_cmd,
  output logic [WORD_BITS-1:0] o_word,
  output logic                 o_busy,
  output logic [CNT_BITS-1:0]  o_word_cnt,
  output logic                 o_overrun
);

  localparam int unsigned BIT_CNT_W = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_BITS - 1);
  localparam logic [WORD_BITS-1:0] SEED_EFF = (SEED == '0) ? WORD_BITS'(1) : SEED;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;

  localparam logic [1:0] CMD_HOLD     = 2'b00;
  localparam logic [1:0] CMD_STEP     = 2'b01;
  localparam logic [1:0] CMD_RESEED   = 2'b10;
  localparam logic [1:0] CMD_STEP_INV = 2'b11;

  logic [1:0]           state_q,   state_d;
  logic [WORD_BITS-1:0] lfsr_q,    lfsr_d;
  logic [WORD_BITS-1:0] shreg_q,   shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 inv_q,     inv_d;
  logic [WORD_BITS-1:0] word_q,    word_d;
  logic [CNT_BITS-1:0]  cnt_q,     cnt_d;
  logic                 ovr_q,     ovr_d;
  logic                 busy_q,    busy_d;
  logic                 capt_q;

  logic                 event_c;
  logic                 step_out_c;
  logic [WORD_BITS-1:0] lfsr_step_c;

  assign event_c     = i_capt_st & ~capt_q;
  assign step_out_c  = lfsr_q[0];
  assign lfsr_step_c = (lfsr_q >> 1) ^ (step_out_c ? TAPS : '0);

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    inv_d     = inv_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (event_c) begin
          case (i_cmd)
            CMD_STEP, CMD_STEP_INV: begin
              state_d   = S_GEN;
              bit_cnt_d = '0;
              shreg_d   = '0;
              inv_d     = (i_cmd == CMD_STEP_INV);
              // An all-zero LFSR would never leave zero; force it out first
              if (lfsr_q == '0) lfsr_d = WORD_BITS'(1);
            end
            CMD_RESEED: begin
              lfsr_d = SEED_EFF;
              word_d = SEED_EFF;
              cnt_d  = '0;
              ovr_d  = 1'b0;
            end
            CMD_HOLD: ;
            default: ;
          endcase
        end
      end
      S_GEN: begin
        lfsr_d    = lfsr_step_c;
        shreg_d   = {shreg_q[WORD_BITS-2:0], step_out_c};
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) state_d = S_LOAD;
        if (event_c) ovr_d = 1'b1;
      end
      S_LOAD: begin
        word_d  = inv_q ? ~shreg_q : shreg_q;
        cnt_d   = cnt_q + CNT_BITS'(1);
        state_d = S_IDLE;
        if (event_c) ovr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      inv_q     <= 1'b0;
      word_q    <= SEED_EFF;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      capt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      inv_q     <= inv_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      capt_q    <= i_capt_st;
    end
  end

  assign o_word     = word_q;
  assign o_busy     = busy_q;
  assign o_word_cnt = cnt_q;
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_prs_word_gen.sv
// Scoreboard bench for prs_word_gen: stimulus pushes expected words, a monitor
// pops and compares each time a generation completes (o_busy falls).
module tb_prs_word_gen;

  logic        clk;
  logic        rst_n;
  logic        capt;
  logic [1:0]  cmd;
  logic [15:0] word;
  logic        busy;
  logic [7:0]  wcnt;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] w;
    logic [7:0]  c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  logic busy_prev = 1'b0;

  prs_word_gen dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_capt_st  (capt),
    .i_cmd      (cmd),
    .o_word     (word),
    .o_busy     (busy),
    .o_word_cnt (wcnt),
    .o_overrun  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Independent reference of one word generation: returns {word, next_lfsr}
  function automatic logic [31:0] model_gen(input logic [15:0] s);
    logic [15:0] st;
    logic [15:0] w;
    st = (s == 16'h0) ? 16'h1 : s;
    w  = 16'h0;
    for (int i = 0; i < 16; i++) begin
      w  = {w[14:0], st[0]};
      st = st[0] ? ((st >> 1) ^ 16'hB400) : (st >> 1);
    end
    return {w, st};
  endfunction

  // Monitor: a completed word is presented when o_busy falls
  always @(negedge clk) begin
    if (rst_n && busy_prev && !busy) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {16'h0, word}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word", {16'h0, word}, {16'h0, e.w});
        check("word_cnt", {24'h0, wcnt}, {24'h0, e.c});
        check("overrun", {31'h0, ovr}, {31'h0, e.o});
      end
    end
    busy_prev = rst_n ? busy : 1'b0;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; capt = 1'b0; cmd = 2'b00;
    repeat (2) @(posedge clk);
    sb.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic frame(input logic [1:0] c, input int hold);
    @(posedge clk); #1;
    cmd = c; capt = 1'b1;
    repeat (hold) @(posedge clk);
    #1 capt = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout act=%0d pending exp=0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] m;

    rst_n = 1'b0; capt = 1'b0; cmd = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_word", {16'h0, word}, 32'hACE1);
    check("rst_cnt", {24'h0, wcnt}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ovr", {31'h0, ovr}, 32'h0);

    // STEP with busy window checks
    sb.push_back('{w: 16'h8723, c: 8'd1, o: 1'b0});
    frame(2'b01, 1);
    @(negedge clk);
    check("busy_T1", {31'h0, busy}, 32'h1);
    check("word_stable_gen", {16'h0, word}, 32'hACE1);
    repeat (16) @(negedge clk);
    check("busy_T17", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("busy_T18", {31'h0, busy}, 32'h0);
    wait_drain();
    check("lfsr_after_step", {16'h0, dut.lfsr_q}, 32'hEB62);

    // RESEED then STEP again
    frame(2'b10, 1);
    @(negedge clk);
    check("reseed_word", {16'h0, word}, 32'hACE1);
    check("reseed_cnt", {24'h0, wcnt}, 32'h0);
    check("reseed_ovr", {31'h0, ovr}, 32'h0);
    check("reseed_busy", {31'h0, busy}, 32'h0);
    sb.push_back('{w: 16'h8723, c: 8'd1, o: 1'b0});
    frame(2'b01, 1);
    wait_drain();

    // STEP_INV from reset
    do_reset();
    sb.push_back('{w: 16'h78DC, c: 8'd1, o: 1'b0});
    frame(2'b11, 1);
    wait_drain();

    // Overrun: second edge during GEN carries RESEED, which must be ignored
    do_reset();
    sb.push_back('{w: 16'h8723, c: 8'd1, o: 1'b1});
    frame(2'b01, 1);
    repeat (4) @(posedge clk);
    #1 cmd = 2'b10; capt = 1'b1;
    repeat (2) @(posedge clk);
    #1 capt = 1'b0;
    wait_drain();
    check("overrun_sticky", {31'h0, ovr}, 32'h1);

    // Strobe held high 10 clocks: exactly one word
    r = model_gen(16'hEB62);
    sb.push_back('{w: r[31:16], c: 8'd2, o: 1'b1});
    frame(2'b01, 10);
    wait_drain();
    repeat (30) @(negedge clk);
    check("held_strobe_cnt", {24'h0, wcnt}, 32'h2);

    // Reset asserted during GEN clock 8
    frame(2'b01, 1);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midgen_word", {16'h0, word}, 32'hACE1);
    check("midgen_busy", {31'h0, busy}, 32'h0);
    check("midgen_cnt", {24'h0, wcnt}, 32'h0);
    check("midgen_ovr", {31'h0, ovr}, 32'h0);
    capt = 1'b0; cmd = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    // 256 STEP frames: counter wraps to 0
    m = 16'hACE1;
    for (int i = 0; i < 256; i++) begin
      r = model_gen(m);
      m = r[15:0];
      sb.push_back('{w: r[31:16], c: 8'(i + 1), o: 1'b0});
      frame(2'b01, 1);
      wait_drain();
    end
    check("cnt_wrap", {24'h0, wcnt}, 32'h0);
    check("busy_final", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
